risac_bus_arbiter: RTL and testbench
====================================

# risac_bus_arbiter

Two-master to one-slave memory arbiter for the risac core. It merges the core's instruction fetch port (read-only) and load/store port (read/write) onto a single pipelined Avalon-MM style memory port. Data accesses have fixed priority, with starvation protection for fetches. An owner/address tag FIFO routes read responses back to the master that issued them.

## Interface
- PENDING, default 4: maximum outstanding reads; power of two, minimum 2.
- STARVE_LIMIT, default 3: number of consecutive cycles an eligible fetch may lose before it is forced a grant; 1 to 15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- iIbusAddr  in  32  fetch byte address.
- iIbusRead  in  1  fetch request.
- oIbusWait  out  1  fetch command not accepted this cycle.
- oIbusData  out  32  fetched word.
- oIbusIAddr  out  32  address of the word on oIbusData.
- oIbusDataValid  out  1  fetch response strobe.
- iDbusAddr  in  32  load/store byte address.
- iDbusRead  in  1  load request.
- iDbusWe  in  1  store request.
- iDbusData  in  32  store data.
- iDbusByteEn  in  4  byte enables.
- oDbusWait  out  1  load/store command not accepted this cycle.
- oDbusData  out  32  load data.
- oDbusDataValid  out  1  load response strobe.
- oMemAddr, oMemData  out  32  slave address and write data.
- oMemRead, oMemWe  out  1  slave read and write commands.
- oMemByteEn  out  4  slave byte enables.
- iMemData  in  32  slave read data.
- iMemWait  in  1  slave waitrequest.
- iMemDataValid  in  1  slave read data valid; responses return in order.
- oErr  out  1  sticky flag: a response arrived with no outstanding read.

## Operation
- Requests:
  - reqD = iDbusWe | iDbusRead.
  - When iDbusWe and iDbusRead are both high, the command is a write and the read is ignored.
  - A D read is eligible only when the FIFO is not full. A D write is always eligible.
  - A fetch is eligible only when iIbusRead is high and the FIFO is not full.
  - Full means count == PENDING, using the registered count. A pop in the same cycle does not free a slot.
- Lock:
  - When a granted command sees iMemWait=1, the lock register stores that owner.
  - In the next cycle, that owner is granted if it still requests; the other master is not considered.
  - The lock clears on acceptance, or when the locked master drops its request.
- Grant when unlocked:
  - D wins by default.
  - I wins if starveCnt == STARVE_LIMIT and the fetch is eligible.
  - Otherwise the single eligible requester wins. With no eligible requester, there is no grant.
- Slave drive:
  - oMem* are a combinational mux of the granted master's signals.
  - For an I grant: oMemRead=1, oMemWe=0, oMemByteEn=4'hF, oMemData=0.
  - With no grant, all oMem* are 0.
- Accept = grant & ~iMemWait.
  - oIbusWait = iIbusRead & ~(I accepted).
  - oDbusWait = reqD & ~(D accepted).
- Tag FIFO:
  - Each accepted read pushes {owner, address}. Writes do not push.
  - Each iMemDataValid pops the head:
    - Owner I: oIbusDataValid=1, oIbusData=iMemData, oIbusIAddr=head address.
    - Owner D: oDbusDataValid=1, oDbusData=iMemData.
  - When valid is low, the data outputs are don't-care; the bench checks only under valid.
  - A simultaneous push and pop leaves count unchanged.
- iMemDataValid with count==0: no pop, no response strobe, and oErr is set until reset.
- starveCnt (4 bits, saturating at STARVE_LIMIT):
  - Increments on each cycle a fetch is eligible and not accepted.
  - Clears on fetch acceptance.

## Timing
- Command path is combinational, from master request to oMem* in the same cycle; the arbiter adds zero cycles.
- Response path is combinational, from iMemDataValid to the owner strobe in the same cycle.
- The only registers are: FIFO storage, rd/wr pointers, count, lock (valid+owner), starveCnt and oErr.
- On reset, all registers clear:
  - count=0, pointers=0, lock invalid, starveCnt=0, oErr=0.
  - With idle inputs, every output is 0.
- A reset asserted with reads outstanding discards all tags. Responses arriving after reset set oErr.

## Test plan
- Single fetch: iIbusRead, addr 0x100, iMemWait=0 → oMemRead=1, oMemAddr=0x100, oIbusWait=0 in cycle 0. Then iMemDataValid with data 0x13 → oIbusDataValid=1, oIbusData=0x13, oIbusIAddr=0x100.
- Contention and starvation (STARVE_LIMIT=3):
  - Both masters request continuously with D reads, with responses returned each cycle.
  - D is accepted in cycles 0-2 and I in cycle 3.
  - starveCnt reads 0,1,2,3, then returns to 0.
- Wait lock: D store to 0x20 with iMemWait=1 for 2 cycles while I requests → D is held granted with oMem* stable, oDbusWait=1 for 2 cycles, then D is accepted. I is granted the following cycle.
- FIFO full (PENDING=4):
  - Issue 4 reads with no responses; the 5th read is stalled with oMemRead=0.
  - A D store is still accepted while the FIFO is full.
  - After one response, the 5th read is accepted the next cycle.
- Ordered routing: issue I@0x0, D@0x40, I@0x4, then three responses A, B, C → I gets A with IAddr 0x0, D gets B, I gets C with IAddr 0x4.
- Errors and reset:
  - iMemDataValid with count=0 → oErr=1 and no strobe.
  - Asserting rst → oErr=0 and count=0.

Source files
------------

// File: rtl/risac_bus_arbiter.sv
// rtl/risac_bus_arbiter.sv - two-master (fetch, load/store) to one-slave pipelined memory arbiter
// D has fixed priority; a starvation counter forces fetch grants; a tag FIFO routes in-order read responses.
module risac_bus_arbiter #(
  parameter int PENDING      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iIbusAddr,
  input  logic        iIbusRead,
  output logic        oIbusWait,
  output logic [31:0] oIbusData,
  output logic [31:0] oIbusIAddr,
  output logic        oIbusDataValid,
  input  logic [31:0] iDbusAddr,
  input  logic        iDbusRead,
  input  logic        iDbusWe,
  input  logic [31:0] iDbusData,
  input  logic [3:0]  iDbusByteEn,
  output logic        oDbusWait,
  output logic [31:0] oDbusData,
  output logic        oDbusDataValid,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  output logic        oMemRead,
  output logic        oMemWe,
  output logic [3:0]  oMemByteEn,
  input  logic [31:0] iMemData,
  input  logic        iMemWait,
  input  logic        iMemDataValid,
  output logic        oErr
);

  localparam int PW = $clog2(PENDING);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(PENDING);
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {GNT_NONE, GNT_D, GNT_I} grantE;

  logic [PW:0]   count;
  logic [PW-1:0] rdPtr, wrPtr;
  logic          tagIbus [PENDING];
  logic [31:0]   tagAddr [PENDING];
  logic          lockValid, lockIbus;
  logic [3:0]    starveCnt;

  grantE grant;
  logic  full, reqD, dRead, dElig, iElig;
  logic  acceptI, acceptD, push, pop, headIbus;
  logic [31:0] headAddr;

  assign full  = (count == FULL_COUNT);
  assign reqD  = iDbusWe | iDbusRead;
  assign dRead = iDbusRead & ~iDbusWe;
  assign dElig = iDbusWe | (iDbusRead & ~full);
  assign iElig = iIbusRead & ~full;

  // A locked owner keeps the bus until accepted; the other master is not looked at.
  always_comb begin
    grant = GNT_NONE;
    if (lockValid) begin
      if (lockIbus) begin
        if (iElig) grant = GNT_I;
      end else if (dElig) begin
        grant = GNT_D;
      end
    end else if (iElig && starveCnt == STARVE_MAX) begin
      grant = GNT_I;
    end else if (dElig) begin
      grant = GNT_D;
    end else if (iElig) begin
      grant = GNT_I;
    end
  end

  always_comb begin
    oMemAddr   = '0;
    oMemData   = '0;
    oMemRead   = 1'b0;
    oMemWe     = 1'b0;
    oMemByteEn = '0;
    case (grant)
      GNT_I: begin
        oMemAddr   = iIbusAddr;
        oMemRead   = 1'b1;
        oMemByteEn = 4'hF;
      end
      GNT_D: begin
        oMemAddr   = iDbusAddr;
        oMemData   = iDbusData;
        oMemRead   = dRead;
        oMemWe     = iDbusWe;
        oMemByteEn = iDbusByteEn;
      end
      default: ;
    endcase
  end

  assign acceptI   = (grant == GNT_I) & ~iMemWait;
  assign acceptD   = (grant == GNT_D) & ~iMemWait;
  assign oIbusWait = iIbusRead & ~acceptI;
  assign oDbusWait = reqD & ~acceptD;

  assign push     = acceptI | (acceptD & dRead);
  assign pop      = iMemDataValid & (count != '0);
  assign headIbus = tagIbus[rdPtr];
  assign headAddr = tagAddr[rdPtr];

  assign oIbusDataValid = pop & headIbus;
  assign oIbusData      = oIbusDataValid ? iMemData : '0;
  assign oIbusIAddr     = oIbusDataValid ? headAddr : '0;
  assign oDbusDataValid = pop & ~headIbus;
  assign oDbusData      = oDbusDataValid ? iMemData : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      lockValid <= 1'b0;
      lockIbus  <= 1'b0;
      starveCnt <= '0;
      oErr      <= 1'b0;
      for (int i = 0; i < PENDING; i++) begin
        tagIbus[i] <= 1'b0;
        tagAddr[i] <= '0;
      end
    end else begin
      if (push) begin
        tagIbus[wrPtr] <= acceptI;
        tagAddr[wrPtr] <= acceptI ? iIbusAddr : iDbusAddr;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Lock lives exactly one cycle past each stalled grant; acceptance or a dropped request ends it.
      lockValid <= (grant != GNT_NONE) & iMemWait;
      lockIbus  <= (grant == GNT_I);
      if (acceptI) starveCnt <= '0;
      else if (iElig && starveCnt != STARVE_MAX) starveCnt <= starveCnt + 1'b1;
      if (iMemDataValid && count == '0) oErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_risac_bus_arbiter.sv
// tb/tb_risac_bus_arbiter.sv - directed and randomized checks of risac_bus_arbiter against a queue-based model
module tb_risac_bus_arbiter;

  localparam int PENDING = 4;
  localparam int LIMIT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iIbusAddr, iDbusAddr, iDbusData, iMemData;
  logic        iIbusRead, iDbusRead, iDbusWe, iMemWait, iMemDataValid;
  logic [3:0]  iDbusByteEn;
  logic        oIbusWait, oIbusDataValid, oDbusWait, oDbusDataValid;
  logic [31:0] oIbusData, oIbusIAddr, oDbusData, oMemAddr, oMemData;
  logic        oMemRead, oMemWe, oErr;
  logic [3:0]  oMemByteEn;

  risac_bus_arbiter #(.PENDING(PENDING), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .iIbusAddr(iIbusAddr), .iIbusRead(iIbusRead), .oIbusWait(oIbusWait),
    .oIbusData(oIbusData), .oIbusIAddr(oIbusIAddr), .oIbusDataValid(oIbusDataValid),
    .iDbusAddr(iDbusAddr), .iDbusRead(iDbusRead), .iDbusWe(iDbusWe),
    .iDbusData(iDbusData), .iDbusByteEn(iDbusByteEn), .oDbusWait(oDbusWait),
    .oDbusData(oDbusData), .oDbusDataValid(oDbusDataValid),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemRead(oMemRead), .oMemWe(oMemWe),
    .oMemByteEn(oMemByteEn), .iMemData(iMemData), .iMemWait(iMemWait),
    .iMemDataValid(iMemDataValid), .oErr(oErr)
  );

  always #5 clk = ~clk;

  typedef struct {bit isI; logic [31:0] addr;} tagT;
  tagT tagQ[$];
  int  mLock;    // 0 none, 1 D, 2 I
  int  mStarve;
  bit  mErr;
  int  mGrant;   // 0 none, 1 D, 2 I
  bit  mIElig;
  int  checks = 0;
  int  failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    iIbusAddr = '0; iIbusRead = 0; iDbusAddr = '0; iDbusRead = 0; iDbusWe = 0;
    iDbusData = '0; iDbusByteEn = '0; iMemData = '0; iMemWait = 0; iMemDataValid = 0;
  endtask

  // Expected combinational behaviour from the arbitration rules and the current tag list.
  task automatic modelCheck();
    bit full, dReq, dElig, pop, accepted;
    logic [31:0] eAddr, eData;
    logic eRead, eWe;
    logic [3:0] eBe;
    full   = (tagQ.size() == PENDING);
    dReq   = iDbusWe | iDbusRead;
    dElig  = iDbusWe | (iDbusRead & !full);
    mIElig = iIbusRead & !full;
    if (mLock == 1)      mGrant = dElig ? 1 : 0;
    else if (mLock == 2) mGrant = mIElig ? 2 : 0;
    else if (mIElig && mStarve == LIMIT) mGrant = 2;
    else if (dElig)  mGrant = 1;
    else if (mIElig) mGrant = 2;
    else             mGrant = 0;
    eAddr = 0; eData = 0; eRead = 0; eWe = 0; eBe = 0;
    if (mGrant == 2) begin
      eAddr = iIbusAddr; eRead = 1; eBe = 4'hF;
    end else if (mGrant == 1) begin
      eAddr = iDbusAddr; eData = iDbusData; eWe = iDbusWe;
      eRead = iDbusRead & ~iDbusWe; eBe = iDbusByteEn;
    end
    accepted = (mGrant != 0) && !iMemWait;
    checkVal("memAddr", oMemAddr, eAddr);
    checkVal("memData", oMemData, eData);
    checkVal("memRead", 32'(oMemRead), 32'(eRead));
    checkVal("memWe", 32'(oMemWe), 32'(eWe));
    checkVal("memByteEn", 32'(oMemByteEn), 32'(eBe));
    checkVal("ibusWait", 32'(oIbusWait), 32'(iIbusRead && !(accepted && mGrant == 2)));
    checkVal("dbusWait", 32'(oDbusWait), 32'(dReq && !(accepted && mGrant == 1)));
    pop = iMemDataValid && tagQ.size() > 0;
    checkVal("ibusValid", 32'(oIbusDataValid), 32'(pop && tagQ[0].isI));
    checkVal("dbusValid", 32'(oDbusDataValid), 32'(pop && !tagQ[0].isI));
    if (pop && tagQ[0].isI) begin
      checkVal("ibusData", oIbusData, iMemData);
      checkVal("ibusIAddr", oIbusIAddr, tagQ[0].addr);
    end
    if (pop && !tagQ[0].isI) checkVal("dbusData", oDbusData, iMemData);
    checkVal("err", 32'(oErr), 32'(mErr));
    checkVal("starve", 32'(dut.starveCnt), 32'(mStarve));
  endtask

  task automatic modelUpdate();
    tagT t;
    bit accepted;
    if (rst) begin
      tagQ.delete(); mLock = 0; mStarve = 0; mErr = 0;
      return;
    end
    accepted = (mGrant != 0) && !iMemWait;
    if (iMemDataValid) begin
      if (tagQ.size() > 0) void'(tagQ.pop_front());
      else mErr = 1;
    end
    if (accepted && mGrant == 2) begin
      t.isI = 1; t.addr = iIbusAddr; tagQ.push_back(t);
    end else if (accepted && iDbusRead && !iDbusWe) begin
      t.isI = 0; t.addr = iDbusAddr; tagQ.push_back(t);
    end
    mLock = ((mGrant != 0) && iMemWait) ? mGrant : 0;
    if (accepted && mGrant == 2) mStarve = 0;
    else if (mIElig && mStarve < LIMIT) mStarve++;
  endtask

  task automatic settle();
    @(negedge clk);
    modelCheck();
  endtask

  task automatic advance();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1; setIdle();
    settle(); advance();
    rst = 0;
  endtask

  task automatic drain();
    setIdle();
    for (int k = 0; k < 8 && tagQ.size() > 0; k++) begin
      iMemDataValid = 1; iMemData = $urandom;
      settle(); advance();
    end
    setIdle();
  endtask

  initial begin
    rst = 1; setIdle();
    mLock = 0; mStarve = 0; mErr = 0;
    @(posedge clk); #1;
    doReset();

    // reset state with idle inputs
    settle();
    checkVal("rstMemRead", 32'(oMemRead), 0);
    checkVal("rstErr", 32'(oErr), 0);
    advance();

    // single fetch
    iIbusRead = 1; iIbusAddr = 32'h100;
    settle();
    checkVal("fetchRead", 32'(oMemRead), 1);
    checkVal("fetchAddr", oMemAddr, 32'h100);
    checkVal("fetchWait", 32'(oIbusWait), 0);
    advance();
    setIdle(); iMemDataValid = 1; iMemData = 32'h13;
    settle();
    checkVal("fetchValid", 32'(oIbusDataValid), 1);
    checkVal("fetchData", oIbusData, 32'h13);
    checkVal("fetchIAddr", oIbusIAddr, 32'h100);
    advance();

    // contention and starvation
    doReset();
    iDbusRead = 1; iDbusAddr = 32'h40; iDbusByteEn = 4'hF; iIbusRead = 1; iIbusAddr = 32'h200;
    for (int c = 0; c < 5; c++) begin
      iMemDataValid = (c > 0); iMemData = $urandom;
      settle();
      checkVal("contStarve", 32'(dut.starveCnt), (c <= 3) ? c : 0);
      checkVal("contDWait", 32'(oDbusWait), 32'(c == 3));
      checkVal("contIWait", 32'(oIbusWait), 32'(c != 3));
      advance();
    end
    drain();

    // wait lock
    doReset();
    iDbusWe = 1; iDbusAddr = 32'h20; iDbusData = 32'h5555; iDbusByteEn = 4'hF;
    iIbusRead = 1; iIbusAddr = 32'h300; iMemWait = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      checkVal("lockWe", 32'(oMemWe), 1);
      checkVal("lockAddr", oMemAddr, 32'h20);
      checkVal("lockDWait", 32'(oDbusWait), 1);
      advance();
    end
    iMemWait = 0;
    settle();
    checkVal("lockAccept", 32'(oDbusWait), 0);
    checkVal("lockIWait", 32'(oIbusWait), 1);
    advance();
    iDbusWe = 0;
    settle();
    checkVal("lockIGrant", oMemAddr, 32'h300);
    checkVal("lockIWait2", 32'(oIbusWait), 0);
    advance();
    drain();

    // FIFO full
    doReset();
    iDbusRead = 1; iDbusByteEn = 4'hF;
    for (int k = 0; k < 4; k++) begin
      iDbusAddr = 32'h1000 + 32'(4 * k);
      settle();
      checkVal("fillDWait", 32'(oDbusWait), 0);
      advance();
    end
    iDbusAddr = 32'h1010;
    settle();
    checkVal("fullRead", 32'(oMemRead), 0);
    checkVal("fullDWait", 32'(oDbusWait), 1);
    advance();
    iDbusRead = 0; iDbusWe = 1; iDbusAddr = 32'h2000; iDbusData = 32'hCAFE;
    settle();
    checkVal("fullStoreWe", 32'(oMemWe), 1);
    checkVal("fullStoreWait", 32'(oDbusWait), 0);
    advance();
    iDbusWe = 0; iDbusRead = 1; iDbusAddr = 32'h1010; iMemDataValid = 1; iMemData = 32'h77;
    settle();
    checkVal("fullPopSameCycle", 32'(oMemRead), 0);
    advance();
    iMemDataValid = 0;
    settle();
    checkVal("fullRetry", 32'(oMemRead), 1);
    checkVal("fullRetryAddr", oMemAddr, 32'h1010);
    advance();
    drain();

    // ordered routing
    doReset();
    iIbusRead = 1; iIbusAddr = 32'h0;
    settle(); advance();
    setIdle(); iDbusRead = 1; iDbusAddr = 32'h40;
    settle(); advance();
    setIdle(); iIbusRead = 1; iIbusAddr = 32'h4;
    settle(); advance();
    setIdle(); iMemDataValid = 1; iMemData = 32'hA;
    settle();
    checkVal("ordA", oIbusData, 32'hA);
    checkVal("ordAAddr", oIbusIAddr, 32'h0);
    advance();
    iMemData = 32'hB;
    settle();
    checkVal("ordBValid", 32'(oDbusDataValid), 1);
    checkVal("ordB", oDbusData, 32'hB);
    advance();
    iMemData = 32'hC;
    settle();
    checkVal("ordC", oIbusData, 32'hC);
    checkVal("ordCAddr", oIbusIAddr, 32'h4);
    advance();

    // spurious response and reset
    doReset();
    iMemDataValid = 1; iMemData = 32'hEE;
    settle();
    checkVal("errNoIStrobe", 32'(oIbusDataValid), 0);
    checkVal("errNoDStrobe", 32'(oDbusDataValid), 0);
    advance();
    setIdle();
    settle();
    checkVal("errSet", 32'(oErr), 1);
    advance();
    doReset();
    settle();
    checkVal("errCleared", 32'(oErr), 0);
    checkVal("countCleared", 32'(dut.count), 0);
    advance();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      iIbusRead     = ($urandom_range(0, 2) != 0);
      iIbusAddr     = $urandom;
      iDbusRead     = ($urandom_range(0, 1) == 1);
      iDbusWe       = ($urandom_range(0, 3) == 0);
      iDbusAddr     = $urandom;
      iDbusData     = $urandom;
      iDbusByteEn   = 4'($urandom);
      iMemWait      = ($urandom_range(0, 3) == 0);
      iMemData      = $urandom;
      iMemDataValid = (tagQ.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
      settle(); advance();
    end
    rst = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
